seq_or_monitor: RTL and testbench

//  RTL checker implementing a parametrised multi-branch OR sequence with per-thread local

---
 rtl/seq_or_pkg.sv | 32 +++
 rtl/seq_or_sat_cnt.sv | 28 ++
 rtl/seq_or_monitor.sv | 172 +++++++++++++++++
 tb/tb_seq_or_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_or_pkg.sv
// Shared types and elaboration helpers for the multi-branch OR sequence monitor.
// Branch delays travel as a packed vector of 4-bit fields, branch 0 in the low nibble.
package seq_or_pkg;

    localparam int unsigned MAX_BR = 8;
    localparam int unsigned MAX_VW = 32;
    localparam int unsigned DLY_W  = 4;

    typedef logic [MAX_BR*DLY_W-1:0] dly_vec_t;

    // One age slot: every branch of one attempt, sized for the widest configuration.
    typedef struct packed {
        logic                           started;
        logic [MAX_BR-1:0]              alive;
        logic [MAX_BR-1:0][MAX_VW-1:0]  v;
    } slot_t;

    function automatic int unsigned dly_at(input dly_vec_t dly, input int unsigned k);
        return 32'(dly[k*DLY_W +: DLY_W]);
    endfunction

    // Number of ages an attempt can live: launch, check, e compare, c_tail.
    function automatic int unsigned seq_len(input dly_vec_t dly, input int unsigned nbr);
        int unsigned mx;
        mx = 0;
        for (int unsigned k = 0; k < nbr; k++) begin
            if (dly_at(dly, k) > mx) mx = dly_at(dly, k);
        end
        return mx + 3;
    endfunction

endpackage

// File: rtl/seq_or_sat_cnt.sv
// Accumulating counter that adds a small increment each cycle and sticks at all-ones.
module seq_or_sat_cnt #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ADD_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADD_W-1:0] add,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned SW = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;
    localparam logic [SW-1:0] CntMax = (SW'(1) << CNT_W) - SW'(1);

    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        sum   = SW'(cnt) + SW'(add);
        cnt_d = (sum > CntMax) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_d;
    end

endmodule

// File: rtl/seq_or_monitor.sv
// Synthesizable checker for an OR of per-branch local-variable sequences, one attempt
// launched per enabled cycle and tracked through a shift register of age slots.
module seq_or_monitor
    import seq_or_pkg::*;
#(
    parameter int unsigned          NUM_BR = 2,
    parameter int unsigned          VW     = 8,
    parameter logic [NUM_BR*4-1:0]  BR_DLY = {4'd2, 4'd1},
    parameter bit                   STRICT = 1'b0,
    parameter int unsigned          CNT_W  = 16,
    localparam int unsigned         L      = seq_len(dly_vec_t'(BR_DLY), NUM_BR),
    localparam int unsigned         NW     = $clog2(L + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_BR-1:0]    start,
    input  logic [NUM_BR*VW-1:0] br_val,
    input  logic [NUM_BR*VW-1:0] chk_val,
    input  logic [VW-1:0]        e_val,
    input  logic                 c_tail,
    output logic                 pass,
    output logic                 fail,
    output logic [2:0]           pass_br,
    output logic [NW-1:0]        pass_num,
    output logic [NW-1:0]        fail_num,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);

    localparam dly_vec_t DLY_X = dly_vec_t'(BR_DLY);

    // Inputs widened to the package slot layout (VW must not exceed MAX_VW).
    logic [MAX_BR-1:0]             start_x;
    logic [MAX_BR-1:0][MAX_VW-1:0] br_x;
    logic [MAX_BR-1:0][MAX_VW-1:0] chk_x;
    logic [MAX_VW-1:0]             e_x;

    always_comb begin
        start_x = '0;
        br_x    = '0;
        chk_x   = '0;
        for (int k = 0; k < NUM_BR; k++) begin
            start_x[k] = start[k];
            br_x[k]    = MAX_VW'(br_val[k*VW +: VW]);
            chk_x[k]   = MAX_VW'(chk_val[k*VW +: VW]);
        end
    end

    assign e_x = MAX_VW'(e_val);

    slot_t slot_q   [1:L-1];
    slot_t slot_cur [L];

    logic [L-1:0][MAX_BR-1:0] alive_nxt;
    logic [L-1:0][2:0]        br_a;
    logic [L-1:0]             match_a;
    logic [L-1:0]             fail_a;
    logic                     strict_fail;

    assign strict_fail = STRICT && enable && (start == '0);

    // Age 0 is the launch cycle itself and is never registered.
    always_comb begin
        slot_cur[0] = '{started: enable, alive: start_x, v: br_x};
        for (int a = 1; a < L; a++) slot_cur[a] = slot_q[a];
    end

    for (genvar a = 0; a < L; a++) begin : g_age
        localparam int unsigned AGE = a;

        logic [MAX_BR-1:0] live;
        logic [MAX_BR-1:0] kill;
        logic [MAX_BR-1:0] hit;
        logic [2:0]        br;

        assign live = slot_cur[a].started ? slot_cur[a].alive : '0;

        always_comb begin
            kill = '0;
            hit  = '0;
            br   = '0;
            for (int k = 0; k < MAX_BR; k++) begin
                if (live[k]) begin
                    if (AGE == dly_at(DLY_X, k)) begin
                        kill[k] = chk_x[k] != slot_cur[a].v[k];
                    end else if (AGE == dly_at(DLY_X, k) + 1) begin
                        kill[k] = e_x != slot_cur[a].v[k];
                    end else if (AGE == dly_at(DLY_X, k) + 2) begin
                        hit[k]  = c_tail;
                        kill[k] = ~c_tail;
                    end
                end
            end
            for (int k = MAX_BR - 1; k >= 0; k--) begin
                if (hit[k]) br = 3'(k);
            end
        end

        // A match retires the whole attempt, so sibling kills never turn into a fail.
        assign match_a[a]   = |hit;
        assign alive_nxt[a] = match_a[a] ? '0 : (live & ~kill);
        assign br_a[a]      = br;
        assign fail_a[a]    = ((|live) & ~(|(live & ~kill)) & ~match_a[a])
                            | ((AGE == 0) & strict_fail);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 1; a < L; a++) slot_q[a] <= '0;
        end else begin
            for (int a = 1; a < L; a++) begin
                slot_q[a] <= '{started: slot_cur[a-1].started,
                               alive:   alive_nxt[a-1],
                               v:       slot_cur[a-1].v};
            end
        end
    end

    logic [NW-1:0] pnum_d;
    logic [NW-1:0] fnum_d;
    logic [2:0]    br_d;

    // Ascending scan leaves the oldest passing slot's branch in br_d.
    always_comb begin
        pnum_d = '0;
        fnum_d = '0;
        br_d   = pass_br;
        for (int a = 0; a < L; a++) begin
            pnum_d = pnum_d + NW'(match_a[a]);
            fnum_d = fnum_d + NW'(fail_a[a]);
            if (match_a[a]) br_d = br_a[a];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass     <= 1'b0;
            fail     <= 1'b0;
            pass_br  <= '0;
            pass_num <= '0;
            fail_num <= '0;
        end else begin
            pass     <= |match_a;
            fail     <= |fail_a;
            pass_br  <= br_d;
            pass_num <= pnum_d;
            fail_num <= fnum_d;
        end
    end

    seq_or_sat_cnt #(
        .CNT_W (CNT_W),
        .ADD_W (NW)
    ) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .add   (pnum_d),
        .cnt   (pass_cnt)
    );

    seq_or_sat_cnt #(
        .CNT_W (CNT_W),
        .ADD_W (NW)
    ) u_fail_cnt (
        .clk   (clk),
        .reset (reset),
        .add   (fnum_d),
        .cnt   (fail_cnt)
    );

endmodule

// File: tb/tb_seq_or_monitor.sv
// Scoreboard bench: default, STRICT=1 and CNT_W=2 monitors side by side on shared stimulus.
module tb_seq_or_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        en_s;
    logic [1:0]  start;
    logic [15:0] br_val;
    logic [15:0] chk_val;
    logic [7:0]  e_val;
    logic        c_tail;

    logic        pass, fail;
    logic [2:0]  pass_br;
    logic [2:0]  pass_num, fail_num;
    logic [15:0] pass_cnt, fail_cnt;

    logic        s_pass, s_fail;
    logic [2:0]  s_pass_br;
    logic [2:0]  s_pass_num, s_fail_num;
    logic [15:0] s_pass_cnt, s_fail_cnt;

    logic        c_pass, c_fail;
    logic [2:0]  c_pass_br;
    logic [2:0]  c_pass_num, c_fail_num;
    logic [1:0]  c_pass_cnt, c_fail_cnt;

    seq_or_monitor dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .br_val(br_val),
        .chk_val(chk_val), .e_val(e_val), .c_tail(c_tail), .pass(pass), .fail(fail),
        .pass_br(pass_br), .pass_num(pass_num), .fail_num(fail_num),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    seq_or_monitor #(.STRICT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .enable(en_s), .start(start), .br_val(br_val),
        .chk_val(chk_val), .e_val(e_val), .c_tail(c_tail), .pass(s_pass), .fail(s_fail),
        .pass_br(s_pass_br), .pass_num(s_pass_num), .fail_num(s_fail_num),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
    );

    seq_or_monitor #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .br_val(br_val),
        .chk_val(chk_val), .e_val(e_val), .c_tail(c_tail), .pass(c_pass), .fail(c_fail),
        .pass_br(c_pass_br), .pass_num(c_pass_num), .fail_num(c_fail_num),
        .pass_cnt(c_pass_cnt), .fail_cnt(c_fail_cnt)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    typedef struct {
        int cyc;
        bit pass;
        bit fail;
        int br;
        bit s_fail;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   exp_pcnt = 0, exp_fcnt = 0, exp_sfcnt = 0, exp_br = 0;

    task automatic push_exp(input int c, input bit p, input bit f, input int b, input bit s);
        exp_t x;
        x.cyc = c; x.pass = p; x.fail = f; x.br = b; x.s_fail = s;
        exp_q.push_back(x);
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Any cycle without a queued entry must be silent on every monitor.
    always @(negedge clk) begin
        e.cyc = cyc; e.pass = 1'b0; e.fail = 1'b0; e.br = exp_br; e.s_fail = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        if (reset) begin
            exp_pcnt = 0; exp_fcnt = 0; exp_sfcnt = 0; exp_br = 0;
        end else begin
            exp_pcnt  += int'(e.pass);
            exp_fcnt  += int'(e.fail);
            exp_sfcnt += int'(e.s_fail);
            if (e.pass) exp_br = e.br;
        end
        check_eq("pass",       int'(pass),       int'(e.pass));
        check_eq("fail",       int'(fail),       int'(e.fail));
        check_eq("pass_num",   int'(pass_num),   int'(e.pass));
        check_eq("fail_num",   int'(fail_num),   int'(e.fail));
        check_eq("pass_br",    int'(pass_br),    exp_br);
        check_eq("pass_cnt",   int'(pass_cnt),   exp_pcnt);
        check_eq("fail_cnt",   int'(fail_cnt),   exp_fcnt);
        check_eq("s_pass",     int'(s_pass),     0);
        check_eq("s_fail",     int'(s_fail),     int'(e.s_fail));
        check_eq("s_fail_cnt", int'(s_fail_cnt), exp_sfcnt);
        check_eq("c_pass_cnt", int'(c_pass_cnt), sat3(exp_pcnt));
        check_eq("c_fail_cnt", int'(c_fail_cnt), sat3(exp_fcnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable  = 1'b1;
        en_s    = 1'b0;
        start   = '0;
        br_val  = '0;
        chk_val = '0;
        e_val   = '0;
        c_tail  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();

        // 1: branch 0 alone; enable drops while in flight and must not launch new attempts
        start = 2'b01; br_val[7:0] = 8'd1;
        push_exp(cyc + 4, 1'b1, 1'b0, 0, 1'b0);
        step();
        enable = 1'b0; chk_val[7:0] = 8'd1;
        step();
        chk_val = '0; e_val = 8'd1;
        step();
        e_val = '0; c_tail = 1'b1;
        step();
        idle();
        repeat (4) step();

        // 2: branch 0 killed at its check (else it would pass at t+4), branch 1 wins
        start = 2'b11; br_val = {8'd2, 8'd1};
        push_exp(cyc + 5, 1'b1, 1'b0, 1, 1'b0);
        step();
        start = '0; br_val = '0; chk_val = {8'd0, 8'd3};
        step();
        chk_val = {8'd2, 8'd0}; e_val = 8'd1;
        step();
        chk_val = '0; e_val = 8'd2; c_tail = 1'b1;
        step();
        e_val = '0; c_tail = 1'b1;
        step();
        idle();
        repeat (4) step();

        // 3: both branches die at their checks, fail reported once the last one dies
        start = 2'b11; br_val = {8'd2, 8'd1};
        push_exp(cyc + 3, 1'b0, 1'b1, 0, 1'b0);
        step();
        start = '0; br_val = '0; chk_val = '0;
        step();
        chk_val = '0;
        step();
        idle();
        repeat (4) step();

        // 5: empty enabled cycles fail only on the STRICT monitor
        en_s = 1'b1;
        push_exp(cyc + 1, 1'b0, 1'b0, 0, 1'b1);
        push_exp(cyc + 2, 1'b0, 1'b0, 0, 1'b1);
        push_exp(cyc + 3, 1'b0, 1'b0, 0, 1'b1);
        repeat (3) step();
        en_s = 1'b0;
        repeat (4) step();

        // 4: six overlapping attempts, six back-to-back passes; also saturates CNT_W=2
        for (int i = 0; i < 6; i++) begin
            start = 2'b01; br_val[7:0] = 8'd5; chk_val[7:0] = 8'd5; e_val = 8'd5; c_tail = 1'b1;
            push_exp(cyc + 4, 1'b1, 1'b0, 0, 1'b0);
            step();
        end
        start = '0;
        repeat (3) step();
        idle();
        repeat (4) step();

        // 6: reset mid-flight drops the attempt and clears counters
        start = 2'b11; br_val = {8'd2, 8'd1};
        step();
        start = '0; br_val = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
